// File: rtl/mux4_rr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mux4_arb_pkg
// Shared types and helpers for the 4-input round-robin mux arbiter.
//   NUM_REQ     : number of requesters / mux inputs (4)
//   IDX_W       : width of a requester index (2)
//   arb_state_t : arbiter FSM states IDLE / GRANT / GAP
//   wrap_inc()  : index increment that wraps 3 -> 0
//   onehot()    : index to one-hot request vector
// ---------------------------------------------------------------------------
package mux4_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef logic [IDX_W-1:0]   idx_t;
    typedef logic [NUM_REQ-1:0] req_vec_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    // The index width exactly covers NUM_REQ, so natural overflow is the wrap.
    function automatic idx_t wrap_inc(input idx_t i);
        return i + idx_t'(1);
    endfunction

    function automatic req_vec_t onehot(input idx_t i);
        req_vec_t v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// mux4_rr_arbiter_if
// Request / grant / select bundle between the requesters and the arbiter.
//   req       : request per mux input (req[k] owns input i<k>)
//   gnt       : one-hot grant or all-zero
//   s1, s0    : mux selects, {s1,s0} = granted index
//   sel_valid : selects reflect a live grant
//   preempt   : one-cycle pulse after a hold-limit forced release
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface mux4_rr_arbiter_if;
    import mux4_arb_pkg::*;

    req_vec_t req;
    req_vec_t gnt;
    logic     s0;
    logic     s1;
    logic     sel_valid;
    logic     preempt;

    modport master (output req, input gnt, s0, s1, sel_valid, preempt);
    modport slave  (input req, output gnt, s0, s1, sel_valid, preempt);

endinterface

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// ---------------------------------------------------------------------------
// rr_pick4
// Purely combinational round-robin picker. Scans req starting at ptr and
// moving upward modulo 4; the first set bit is reported.
//   req[3:0] : request vector
//   ptr[1:0] : search start index
//   found    : at least one request is set
//   idx[1:0] : winning index (equals ptr when nothing is found)
// ---------------------------------------------------------------------------
module rr_pick4
    import mux4_arb_pkg::*;
(
    input  req_vec_t req,
    input  idx_t     ptr,
    output logic     found,
    output idx_t     idx
);

    always_comb begin
        idx_t cand;
        // NOTE: every variable written here gets a default first so that no
        // path through the loop leaves one unassigned and infers a latch.
        found = 1'b0;
        idx   = ptr;
        cand  = ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = ptr + idx_t'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux4_rr_arbiter
// Round-robin arbiter and select controller for a shared 4:1 single-bit mux.
// Grants one requester at a time, drives the mux selects to the owner, and
// inserts a one-cycle break-before-make GAP between owners. All outputs are
// registered; the selects only move on entry to GRANT.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : mux4_rr_arbiter_if.slave (req in; gnt, s1, s0, sel_valid,
//           preempt out)
// Parameter HOLD_MAX (2..255): max consecutive grant cycles per owner.
// Optional feature macro: MUX4_ARB_HOLD_LIMIT_EN enables the hold-limit
// counter and the preempt pulse; without it grants last until release.
// ---------------------------------------------------------------------------
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int HOLD_MAX = 8
) (
    input logic              clk,
    input logic              rst_n,
    mux4_rr_arbiter_if.slave bus
);

    if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
        $error("HOLD_MAX must be in 2..255");
    end

    arb_state_t state_q, state_d;
    idx_t       owner_q, owner_d;
    idx_t       ptr_q, ptr_d;
    req_vec_t   gnt_q;
    logic       sel_valid_q;
    logic       pick_found;
    idx_t       pick_idx;

    rr_pick4 u_pick (
        .req   (bus.req),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

`ifdef MUX4_ARB_HOLD_LIMIT_EN
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
    logic [7:0] hold_cnt_q;
    logic       preempt_q;
    logic       force_rel;
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
`ifdef MUX4_ARB_HOLD_LIMIT_EN
        force_rel = 1'b0;
`endif
        case (state_q)
            IDLE, GAP: begin
                if (pick_found) begin
                    state_d = GRANT;
                    owner_d = pick_idx;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (!bus.req[owner_q]) begin
                    state_d = GAP;
                    ptr_d   = wrap_inc(owner_q);
                end
`ifdef MUX4_ARB_HOLD_LIMIT_EN
                else if (hold_cnt_q == HOLD_LAST) begin
                    state_d   = GAP;
                    ptr_d     = wrap_inc(owner_q);
                    force_rel = 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state and outputs use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous; it is just the highest-priority branch
        // of the clocked update, so it also applies mid-grant.
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            ptr_q       <= '0;
            gnt_q       <= '0;
            sel_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            gnt_q       <= (state_d == GRANT) ? onehot(owner_d) : '0;
            sel_valid_q <= (state_d == GRANT);
        end
    end

`ifdef MUX4_ARB_HOLD_LIMIT_EN
    // Counter is zero on the entry edge and counts each cycle spent in GRANT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_cnt_q <= '0;
            preempt_q  <= 1'b0;
        end else begin
            hold_cnt_q <= (state_q == GRANT) ? hold_cnt_q + 8'd1 : 8'd0;
            preempt_q  <= force_rel;
        end
    end

    assign bus.preempt = preempt_q;
`else
    assign bus.preempt = 1'b0;
`endif

    // owner_q only changes on entry to GRANT, so it doubles as the select
    // register and holds the previous owner through GAP and IDLE.
    assign bus.gnt       = gnt_q;
    assign bus.s1        = owner_q[1];
    assign bus.s0        = owner_q[0];
    assign bus.sel_valid = sel_valid_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux4_rr_arbiter
// Directed bench for mux4_rr_arbiter (HOLD_MAX = 4). Each step drives req,
// pushes the expected registered outputs, then compares one edge later.
// Hold-limit expectations follow MUX4_ARB_HOLD_LIMIT_EN.
// ---------------------------------------------------------------------------
module tb_mux4_rr_arbiter;
    import mux4_arb_pkg::*;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       valid;
        logic       preempt;
    } obs_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mux4_rr_arbiter_if bus ();

    mux4_rr_arbiter #(.HOLD_MAX(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    obs_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;

    // External mux model: i0..i3 = 1,1,0,1.
    logic [3:0] mux_in = 4'b1011;
    logic       exp_y[4] = '{1'b1, 1'b1, 1'b0, 1'b1};

    function automatic obs_t mk(input logic [3:0] g, input int s,
                                input logic v, input logic p);
        obs_t o;
        o.gnt     = g;
        o.sel     = 2'(s);
        o.valid   = v;
        o.preempt = p;
        return o;
    endfunction

    function automatic logic mux4to1(input logic [3:0] i, input logic s1,
                                     input logic s0);
        return i[{s1, s0}];
    endfunction

    task automatic step(input logic [3:0] r, input obs_t e, input string tag);
        obs_t  o;
        obs_t  x;
        string t;
        bus.req = r;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        o = {bus.gnt, bus.s1, bus.s0, bus.sel_valid, bus.preempt};
        x = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert (o === x) else begin
            errors++;
            $error("FAIL %s: observed gnt=%b sel=%0d valid=%b preempt=%b, expected gnt=%b sel=%0d valid=%b preempt=%b",
                   t, o.gnt, o.sel, o.valid, o.preempt,
                   x.gnt, x.sel, x.valid, x.preempt);
        end
    endtask

    initial begin
        int  o;
        logic y;
        bus.req = '0;

        // Reset state
        rst_n = 1'b0;
        step(4'b0000, mk(4'b0000, 0, 0, 0), "reset");
        step(4'b0000, mk(4'b0000, 0, 0, 0), "reset_hold");
        rst_n = 1'b1;

        // Grant 2, release (ptr -> 3), grant 2 again, then reset mid-grant
        step(4'b0100, mk(4'b0100, 2, 1, 0), "first_grant");
        step(4'b0000, mk(4'b0000, 2, 0, 0), "first_release");
        step(4'b0100, mk(4'b0100, 2, 1, 0), "regrant_2");
        step(4'b0100, mk(4'b0100, 2, 1, 0), "hold_2");
        rst_n = 1'b0;
        step(4'b0100, mk(4'b0000, 0, 0, 0), "reset_mid_grant");
        rst_n = 1'b1;

        // Simultaneous requests: order 0,1,2,3,0 with a GAP after each
        for (int k = 0; k < 5; k++) begin
            o = k % 4;
            repeat (3) step(4'b1111, mk(onehot(2'(o)), o, 1, 0), "simul_grant");
            step(4'b1111 & ~onehot(2'(o)), mk(4'b0000, o, 0, 0), "simul_gap");
        end
        step(4'b0000, mk(4'b0000, 0, 0, 0), "to_idle");

        // Latency: single req[3] from IDLE, then release
        step(4'b1000, mk(4'b1000, 3, 1, 0), "latency_grant");
        step(4'b0000, mk(4'b0000, 3, 0, 0), "latency_release");

        // Wrap: owner 3 releases with req = 0011 -> index 0 next
        step(4'b1000, mk(4'b1000, 3, 1, 0), "wrap_grant3");
        step(4'b0011, mk(4'b0000, 3, 0, 0), "wrap_gap");
        step(4'b0011, mk(4'b0001, 0, 1, 0), "wrap_grant0");
        step(4'b0000, mk(4'b0000, 0, 0, 0), "wrap_release");
        step(4'b0000, mk(4'b0000, 0, 0, 0), "wrap_idle");

        // Hold limit: req[1] held with req[2] pending (ptr = 1)
        repeat (4) step(4'b0110, mk(4'b0010, 1, 1, 0), "hold_grant1");
`ifdef MUX4_ARB_HOLD_LIMIT_EN
        step(4'b0110, mk(4'b0000, 1, 0, 1), "hold_preempt");
        step(4'b0110, mk(4'b0100, 2, 1, 0), "hold_next2");
        step(4'b0000, mk(4'b0000, 2, 0, 0), "hold_release2");
        // Sole requester is re-granted after the forced gap
        repeat (4) step(4'b0001, mk(4'b0001, 0, 1, 0), "sole_grant0");
        step(4'b0001, mk(4'b0000, 0, 0, 1), "sole_preempt");
        step(4'b0001, mk(4'b0001, 0, 1, 0), "sole_regrant");
        step(4'b0000, mk(4'b0000, 0, 0, 0), "sole_release");
        step(4'b0000, mk(4'b0000, 0, 0, 0), "sole_idle");
`else
        repeat (8) step(4'b0110, mk(4'b0010, 1, 1, 0), "nolimit_hold1");
        step(4'b0000, mk(4'b0000, 1, 0, 0), "nolimit_release");
        step(4'b0000, mk(4'b0000, 1, 0, 0), "nolimit_idle");
`endif

        // Mux integration: grant each index in turn and check y
        for (int k = 0; k < 4; k++) begin
            step(onehot(2'(k)), mk(onehot(2'(k)), k, 1, 0), "mux_grant");
            y = mux4to1(mux_in, bus.s1, bus.s0);
            checks++;
            assert (y === exp_y[k]) else begin
                errors++;
                $error("FAIL mux_y[%0d]: observed y=%b, expected y=%b",
                       k, y, exp_y[k]);
            end
            step(4'b0000, mk(4'b0000, k, 0, 0), "mux_gap");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
